// File: rtl/prf_wake.sv
// Physical register file with per-register ready tracking: rename marks busy,
// early wakeups count down to ready, write-backs fill data and mark ready.
module prf_wake #(
    parameter int PRNUM = 128,
    parameter int RWD   = 4,
    parameter int NSRC  = 2,
    parameter int EWD   = 4,
    parameter int WKP   = 2,
    parameter int DW    = 64,
    parameter int LMAX  = 7,
    localparam int PW   = $clog2(PRNUM),
    localparam int LW   = $clog2(LMAX + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [RWD-1:0]                      ren_valid,
    input  logic [RWD-1:0][PW-1:0]              ren_prd,
    input  logic [RWD-1:0][NSRC-1:0][PW-1:0]    ren_prs,
    output logic [RWD-1:0][NSRC-1:0]            busy_resp,
    output logic [RWD-1:0][NSRC-1:0][DW-1:0]    rd_data,
    input  logic [WKP-1:0]                      wk_valid,
    input  logic [WKP-1:0][PW-1:0]              wk_prd,
    input  logic [WKP-1:0][LW-1:0]              wk_lat,
    input  logic [EWD-1:0]                      wb_valid,
    input  logic [EWD-1:0][PW-1:0]              wb_prd,
    input  logic [EWD-1:0][DW-1:0]              wb_data,
    input  logic                                flush
);

    // Encoding: READY = {busy 0, cnt 0}; BUSY = {1, 0}; WAKING(c) = {1, c}.
    logic [PRNUM-1:0] busy_q, busy_d;
    logic [LW-1:0]    cnt_q [PRNUM];
    logic [LW-1:0]    cnt_d [PRNUM];
    logic [DW-1:0]    mem_q [PRNUM];
    logic [DW-1:0]    mem_d [PRNUM];
    logic [RWD-1:0][NSRC-1:0][DW-1:0] rd_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q  <= '0;
            rd_data <= '0;
            for (int r = 0; r < PRNUM; r++) begin
                cnt_q[r] <= '0;
                mem_q[r] <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            rd_data <= rd_d;
            for (int r = 0; r < PRNUM; r++) begin
                cnt_q[r] <= cnt_d[r];
                mem_q[r] <= mem_d[r];
            end
        end
    end

    // Effects layered low to high priority: countdown/flush, wakeup, write-back, rename.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < PRNUM; r++) begin
            cnt_d[r] = cnt_q[r];
            mem_d[r] = mem_q[r];
            if (busy_q[r] && cnt_q[r] != '0) begin
                if (flush) begin
                    cnt_d[r] = '0;
                end else if (cnt_q[r] == LW'(1)) begin
                    busy_d[r] = 1'b0;
                    cnt_d[r]  = '0;
                end else begin
                    cnt_d[r] = cnt_q[r] - LW'(1);
                end
            end
            for (int w = 0; w < WKP; w++) begin
                if (wk_valid[w] && wk_prd[w] == PW'(r) && busy_q[r]) begin
                    busy_d[r] = (wk_lat[w] != '0);
                    cnt_d[r]  = wk_lat[w];
                end
            end
            for (int k = 0; k < EWD; k++) begin
                if (wb_valid[k] && wb_prd[k] == PW'(r)) begin
                    busy_d[r] = 1'b0;
                    cnt_d[r]  = '0;
                    mem_d[r]  = wb_data[k];
                end
            end
            for (int i = 0; i < RWD; i++) begin
                if (ren_valid[i] && ren_prd[i] == PW'(r)) begin
                    busy_d[r] = 1'b1;
                    cnt_d[r]  = '0;
                end
            end
        end
        busy_d[0] = 1'b0;
        cnt_d[0]  = '0;
        mem_d[0]  = '0;
    end

    always_comb begin
        busy_resp = '0;
        for (int i = 0; i < RWD; i++) begin
            for (int s = 0; s < NSRC; s++) begin
                busy_resp[i][s] = busy_q[ren_prs[i][s]];
                if (busy_q[ren_prs[i][s]] && cnt_q[ren_prs[i][s]] == LW'(1))
                    busy_resp[i][s] = 1'b0;
                for (int k = 0; k < EWD; k++) begin
                    if (wb_valid[k] && wb_prd[k] == ren_prs[i][s])
                        busy_resp[i][s] = 1'b0;
                end
                for (int w = 0; w < WKP; w++) begin
                    if (wk_valid[w] && wk_lat[w] == '0 && wk_prd[w] == ren_prs[i][s])
                        busy_resp[i][s] = 1'b0;
                end
                // An older slot in the same rename group allocating this source wins.
                for (int j = 0; j < i; j++) begin
                    if (ren_valid[j] && ren_prd[j] == ren_prs[i][s])
                        busy_resp[i][s] = 1'b1;
                end
                if (ren_prs[i][s] == '0)
                    busy_resp[i][s] = 1'b0;
            end
        end
    end

    always_comb begin
        rd_d = '0;
        for (int i = 0; i < RWD; i++) begin
            for (int s = 0; s < NSRC; s++) begin
                rd_d[i][s] = mem_q[ren_prs[i][s]];
                for (int k = 0; k < EWD; k++) begin
                    if (wb_valid[k] && wb_prd[k] == ren_prs[i][s])
                        rd_d[i][s] = wb_data[k];
                end
                if (ren_prs[i][s] == '0)
                    rd_d[i][s] = '0;
            end
        end
    end

endmodule

// File: tb/tb_prf_wake.sv
// Directed and randomized checks of prf_wake against a register-state reference model.
module tb_prf_wake;
    localparam int PRNUM = 128;
    localparam int RWD   = 4;
    localparam int NSRC  = 2;
    localparam int EWD   = 4;
    localparam int WKP   = 2;
    localparam int DW    = 64;
    localparam int LMAX  = 7;
    localparam int PW    = $clog2(PRNUM);
    localparam int LW    = $clog2(LMAX + 1);
    localparam int K_RDY = 0;
    localparam int K_BSY = 1;
    localparam int K_WAK = 2;

    logic                             clk = 1'b0;
    logic                             rst;
    logic [RWD-1:0]                   ren_valid;
    logic [RWD-1:0][PW-1:0]           ren_prd;
    logic [RWD-1:0][NSRC-1:0][PW-1:0] ren_prs;
    logic [RWD-1:0][NSRC-1:0]         busy_resp;
    logic [RWD-1:0][NSRC-1:0][DW-1:0] rd_data;
    logic [WKP-1:0]                   wk_valid;
    logic [WKP-1:0][PW-1:0]           wk_prd;
    logic [WKP-1:0][LW-1:0]           wk_lat;
    logic [EWD-1:0]                   wb_valid;
    logic [EWD-1:0][PW-1:0]           wb_prd;
    logic [EWD-1:0][DW-1:0]           wb_data;
    logic                             flush;

    int tests = 0;
    int fails = 0;

    int            kind [PRNUM];
    int            wcnt [PRNUM];
    logic [DW-1:0] arr  [PRNUM];
    logic [RWD-1:0][NSRC-1:0]         exp_busy;
    logic [RWD-1:0][NSRC-1:0][DW-1:0] exp_rd;

    prf_wake #(
        .PRNUM(PRNUM), .RWD(RWD), .NSRC(NSRC), .EWD(EWD),
        .WKP(WKP), .DW(DW), .LMAX(LMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .ren_valid(ren_valid), .ren_prd(ren_prd), .ren_prs(ren_prs),
        .busy_resp(busy_resp), .rd_data(rd_data),
        .wk_valid(wk_valid), .wk_prd(wk_prd), .wk_lat(wk_lat),
        .wb_valid(wb_valid), .wb_prd(wb_prd), .wb_data(wb_data),
        .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int p = 0; p < PRNUM; p++) begin
            kind[p] = K_RDY;
            wcnt[p] = 0;
            arr[p]  = '0;
        end
    endtask

    function automatic logic model_busy(int i, int s);
        int p;
        p = int'(ren_prs[i][s]);
        if (p == 0) return 1'b0;
        for (int j = 0; j < i; j++)
            if (ren_valid[j] && int'(ren_prd[j]) == p) return 1'b1;
        for (int k = 0; k < EWD; k++)
            if (wb_valid[k] && int'(wb_prd[k]) == p) return 1'b0;
        for (int w = 0; w < WKP; w++)
            if (wk_valid[w] && wk_lat[w] == 0 && int'(wk_prd[w]) == p) return 1'b0;
        if (kind[p] == K_WAK && wcnt[p] == 1) return 1'b0;
        return kind[p] != K_RDY;
    endfunction

    function automatic logic [DW-1:0] model_read(int p);
        logic [DW-1:0] v;
        if (p == 0) return '0;
        v = arr[p];
        for (int k = 0; k < EWD; k++)
            if (wb_valid[k] && int'(wb_prd[k]) == p) v = wb_data[k];
        return v;
    endfunction

    task automatic model_update();
        int nk [PRNUM];
        int nc [PRNUM];
        for (int p = 1; p < PRNUM; p++) begin
            nk[p] = kind[p];
            nc[p] = wcnt[p];
            if (kind[p] == K_WAK) begin
                if (flush) begin
                    nk[p] = K_BSY; nc[p] = 0;
                end else if (wcnt[p] == 1) begin
                    nk[p] = K_RDY; nc[p] = 0;
                end else begin
                    nc[p] = wcnt[p] - 1;
                end
            end
            for (int w = 0; w < WKP; w++) begin
                if (wk_valid[w] && int'(wk_prd[w]) == p && kind[p] != K_RDY) begin
                    nk[p] = (wk_lat[w] == 0) ? K_RDY : K_WAK;
                    nc[p] = int'(wk_lat[w]);
                end
            end
            for (int k = 0; k < EWD; k++) begin
                if (wb_valid[k] && int'(wb_prd[k]) == p) begin
                    nk[p] = K_RDY; nc[p] = 0;
                    arr[p] = wb_data[k];
                end
            end
            for (int i = 0; i < RWD; i++) begin
                if (ren_valid[i] && int'(ren_prd[i]) == p) begin
                    nk[p] = K_BSY; nc[p] = 0;
                end
            end
        end
        for (int p = 1; p < PRNUM; p++) begin
            kind[p] = nk[p];
            wcnt[p] = nc[p];
        end
    endtask

    task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        ren_valid = '0; ren_prd = '0; ren_prs = '0;
        wk_valid = '0; wk_prd = '0; wk_lat = '0;
        wb_valid = '0; wb_prd = '0; wb_data = '0;
        flush = 1'b0;
    endtask

    // Mid-cycle: compare combinational busy and prepare next registered read.
    task automatic check_comb();
        #3;
        for (int i = 0; i < RWD; i++)
            for (int s = 0; s < NSRC; s++) begin
                exp_busy[i][s] = model_busy(i, s);
                exp_rd[i][s]   = model_read(int'(ren_prs[i][s]));
            end
        tests++;
        assert (busy_resp === exp_busy) else begin
            fails++;
            $error("FAIL busy_resp got=%h exp=%h", busy_resp, exp_busy);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        tests++;
        assert (rd_data === exp_rd) else begin
            fails++;
            $error("FAIL rd_data got=%h exp=%h", rd_data, exp_rd);
        end
    endtask

    function automatic logic [PW-1:0] rreg();
        return PW'($urandom_range(0, 15));
    endfunction

    task automatic rand_inputs();
        for (int i = 0; i < RWD; i++) begin
            ren_valid[i] = ($urandom_range(0, 9) < 3);
            ren_prd[i]   = rreg();
            for (int s = 0; s < NSRC; s++) ren_prs[i][s] = rreg();
        end
        for (int w = 0; w < WKP; w++) begin
            wk_valid[w] = ($urandom_range(0, 9) < 3);
            wk_prd[w]   = rreg();
            wk_lat[w]   = LW'($urandom_range(0, LMAX));
        end
        for (int k = 0; k < EWD; k++) begin
            wb_valid[k] = ($urandom_range(0, 9) < 2);
            wb_prd[k]   = rreg();
            wb_data[k]  = {$urandom(), $urandom()};
        end
        flush = ($urandom_range(0, 19) == 0);
    endtask

    initial begin
        logic [0:3] tail_busy;
        tail_busy = 4'b1100;
        rst = 1'b0;
        clear_in();
        model_reset();
        #1;
        chk("reset_rd_all", {32'd0, 32'(rd_data != '0)}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // Rename bypass within a group, then the registered busy state.
        ren_valid[0] = 1'b1; ren_prd[0] = PW'(5); ren_prs[1][0] = PW'(5);
        check_comb();
        chk("ren_bypass", busy_resp[1][0], 1);
        tick();
        clear_in(); ren_prs[0][0] = PW'(5);
        check_comb();
        chk("ren_busy_next", busy_resp[0][0], 1);
        tick();

        // Wakeup latency 3 issued at cycle t.
        wk_valid[0] = 1'b1; wk_prd[0] = PW'(5); wk_lat[0] = LW'(3);
        check_comb();
        chk("wk_t", busy_resp[0][0], 1);
        tick();
        clear_in(); ren_prs[0][0] = PW'(5);
        for (int c = 0; c < 4; c++) begin
            check_comb();
            chk($sformatf("wk_t+%0d", c + 1), busy_resp[0][0], tail_busy[c]);
            tick();
        end

        // Flush of a counting wakeup, then recovery by write-back.
        clear_in(); ren_valid[0] = 1'b1; ren_prd[0] = PW'(5);
        check_comb(); tick();
        clear_in(); wk_valid[1] = 1'b1; wk_prd[1] = PW'(5); wk_lat[1] = LW'(2);
        check_comb(); tick();
        clear_in(); flush = 1'b1; ren_prs[0][0] = PW'(5);
        check_comb(); tick();
        clear_in(); ren_prs[0][0] = PW'(5);
        for (int c = 0; c < 3; c++) begin
            check_comb();
            chk("flush_busy", busy_resp[0][0], 1);
            tick();
        end
        wb_valid[2] = 1'b1; wb_prd[2] = PW'(5); wb_data[2] = 64'hABCD;
        check_comb(); tick();
        chk("wb_after_flush", rd_data[0][0], 64'hABCD);

        // Two write-back ports to one register.
        clear_in();
        wb_valid[0] = 1'b1; wb_prd[0] = PW'(7); wb_data[0] = 64'h11;
        wb_valid[3] = 1'b1; wb_prd[3] = PW'(7); wb_data[3] = 64'h22;
        ren_prs[0][0] = PW'(7);
        check_comb();
        chk("wb_multi_busy", busy_resp[0][0], 0);
        tick();
        chk("wb_multi_data", rd_data[0][0], 64'h22);

        // Rename beats same-cycle write-back; register 0 is constant.
        clear_in();
        ren_valid[0] = 1'b1; ren_prd[0] = PW'(9);
        wb_valid[1] = 1'b1; wb_prd[1] = PW'(9); wb_data[1] = 64'h99;
        wb_valid[2] = 1'b1; wb_prd[2] = PW'(0); wb_data[2] = 64'h77;
        ren_prs[0][1] = PW'(0);
        check_comb();
        chk("zero_busy", busy_resp[0][1], 0);
        tick();
        chk("zero_data", rd_data[0][1], 0);
        clear_in(); ren_prs[0][0] = PW'(9);
        check_comb();
        chk("ren_over_wb", busy_resp[0][0], 1);
        tick();

        // Asynchronous reset during a countdown.
        clear_in(); wb_valid[0] = 1'b1; wb_prd[0] = PW'(12); wb_data[0] = 64'h1234;
        check_comb(); tick();
        clear_in(); ren_valid[1] = 1'b1; ren_prd[1] = PW'(12);
        check_comb(); tick();
        clear_in(); wk_valid[0] = 1'b1; wk_prd[0] = PW'(12); wk_lat[0] = LW'(4);
        check_comb(); tick();
        clear_in(); ren_prs[0][0] = PW'(12);
        check_comb(); tick();
        chk("pre_reset_data", rd_data[0][0], 64'h1234);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_rd", rd_data[0][0], 0);
        model_reset();
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        check_comb();
        chk("post_reset_busy", busy_resp[0][0], 0);
        tick();
        chk("post_reset_data", rd_data[0][0], 0);

        for (int n = 0; n < 400; n++) begin
            clear_in();
            rand_inputs();
            check_comb();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
